// File: rtl/bit_stuff_tx_pkg.sv
// Shared definitions for the bit-stuffing transmitter and the receive-side
// run detector / de-stuffer that must agree on DATA_W and MAX_RUN.
package bit_stuff_tx_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MAX_RUN = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STUFF = 2'd2
   } tx_state_t;

   // What the line carries in the next cycle, decided once and shared by
   // the FSM and the run tracker so both see the same bit.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_LOAD  = 2'd1,
      ACT_DATA  = 2'd2,
      ACT_STUFF = 2'd3
   } tx_act_t;

   function automatic int run_cnt_w(input int max_run);
      return $clog2(max_run + 1);
   endfunction

endpackage

// File: rtl/bit_stuff_tx_if.sv
// Byte-producer handshake plus serial line outputs of the bit-stuffing
// transmitter; master is the producer/line side, slave is the transmitter.
interface bit_stuff_tx_if
   import bit_stuff_tx_pkg::*;
   #(parameter int DATA_W = DEF_DATA_W);

   logic [DATA_W-1:0] data_in;
   logic              load;
   logic              ready;
   logic              w;
   logic              w_valid;
   logic              stuffed;
   logic              busy;

   modport master (
      output data_in,
      output load,
      input  ready,
      input  w,
      input  w_valid,
      input  stuffed,
      input  busy
   );

   modport slave (
      input  data_in,
      input  load,
      output ready,
      output w,
      output w_valid,
      output stuffed,
      output busy
   );

endinterface

// File: rtl/bit_stuff_tx_run_tracker.sv
// Tracks the length of the current run of equal line bits and flags when
// the bit just put on the line has completed a run of MAX_RUN.
module run_tracker
   import bit_stuff_tx_pkg::*;
   #(parameter int MAX_RUN = DEF_MAX_RUN)
   (
      input  logic clock,
      input  logic resetn,
      input  logic clear,
      input  logic bit_valid,
      input  logic bit_in,
      output logic stuff_needed
   );

   localparam int RUN_W = run_cnt_w(MAX_RUN);

   logic             last_bit;
   logic [RUN_W-1:0] run_cnt;

   // A zero count means no line bit precedes this one, so any bit starts
   // a fresh run regardless of last_bit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_bit <= 1'b0;
         run_cnt  <= '0;
      end else if (clear) begin
         last_bit <= 1'b0;
         run_cnt  <= '0;
      end else if (bit_valid) begin
         last_bit <= bit_in;
         if ((run_cnt != '0) && (bit_in == last_bit)) begin
            if (run_cnt != RUN_W'(MAX_RUN))
               run_cnt <= run_cnt + RUN_W'(1);
         end else begin
            run_cnt <= RUN_W'(1);
         end
      end
   end

   assign stuff_needed = (run_cnt == RUN_W'(MAX_RUN));

endmodule

// File: rtl/bit_stuff_tx.sv
// Parallel-to-serial transmitter, LSB first, inserting a complementary
// stuff bit after every MAX_RUN equal line bits.
module bit_stuff_tx
   import bit_stuff_tx_pkg::*;
   #(
      parameter int DATA_W  = DEF_DATA_W,
      parameter int MAX_RUN = DEF_MAX_RUN
   )
   (
      input  logic           clock,
      input  logic           resetn,
      bit_stuff_tx_if.slave  bus
   );

   localparam int CNT_W = $clog2(DATA_W + 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              w_q;
   logic              w_valid_q;
   logic              stuffed_q;

   tx_act_t act;
   logic    word_done;
   logic    stuff_needed;
   logic    ready_c;
   logic    trk_clear;
   logic    trk_valid;
   logic    trk_bit;

   // bit_cnt counts data bits already on the line for the current word.
   assign word_done = (bit_cnt == CNT_W'(DATA_W));

   always_comb begin
      ready_c = 1'b1;
      act     = ACT_HOLD;
      case (state)
         SHIFT: begin
            ready_c = word_done && !stuff_needed;
            if (stuff_needed)
               act = ACT_STUFF;
            else if (!word_done)
               act = ACT_DATA;
            else if (bus.load)
               act = ACT_LOAD;
         end
         STUFF: begin
            ready_c = word_done;
            if (!word_done)
               act = ACT_DATA;
            else if (bus.load)
               act = ACT_LOAD;
         end
         default: begin
            if (bus.load)
               act = ACT_LOAD;
         end
      endcase
   end

   always_comb begin
      trk_bit = 1'b0;
      case (act)
         ACT_LOAD:  trk_bit = bus.data_in[0];
         ACT_DATA:  trk_bit = shreg[0];
         ACT_STUFF: trk_bit = ~w_q;
         default:   trk_bit = 1'b0;
      endcase
   end

   // Going idle breaks the run; anything else puts a bit on the line.
   assign trk_clear = (act == ACT_HOLD);
   assign trk_valid = !trk_clear;

   run_tracker #(.MAX_RUN(MAX_RUN)) u_run_tracker (
      .clock        (clock),
      .resetn       (resetn),
      .clear        (trk_clear),
      .bit_valid    (trk_valid),
      .bit_in       (trk_bit),
      .stuff_needed (stuff_needed)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         w_q       <= 1'b0;
         w_valid_q <= 1'b0;
         stuffed_q <= 1'b0;
      end else begin
         w_q <= trk_bit;
         case (act)
            ACT_LOAD: begin
               state     <= SHIFT;
               shreg     <= bus.data_in >> 1;
               bit_cnt   <= CNT_W'(1);
               w_valid_q <= 1'b1;
               stuffed_q <= 1'b0;
            end
            ACT_DATA: begin
               state     <= SHIFT;
               shreg     <= shreg >> 1;
               bit_cnt   <= bit_cnt + CNT_W'(1);
               w_valid_q <= 1'b1;
               stuffed_q <= 1'b0;
            end
            ACT_STUFF: begin
               state     <= STUFF;
               w_valid_q <= 1'b1;
               stuffed_q <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               bit_cnt   <= '0;
               w_valid_q <= 1'b0;
               stuffed_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready   = ready_c;
   assign bus.w       = w_q;
   assign bus.w_valid = w_valid_q;
   assign bus.stuffed = stuffed_q;
   assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_bit_stuff_tx.sv
// Scoreboard bench for bit_stuff_tx: directed line patterns plus a random
// phase checked by an independent de-stuffer and 4-in-a-row run detector.
module tb_bit_stuff_tx;
   import bit_stuff_tx_pkg::*;

   localparam int DATA_W  = 8;
   localparam int MAX_RUN = 3;

   logic clock  = 1'b0;
   logic resetn = 1'b1;

   bit_stuff_tx_if #(.DATA_W(DATA_W)) bus ();

   bit_stuff_tx #(.DATA_W(DATA_W), .MAX_RUN(MAX_RUN)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic b;
      logic s;
      logic rdy;
      logic c;
   } sym_t;

   sym_t        sym_q[$];
   logic [7:0]  word_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          sym_mode = 1'b1;
   bit          rnd_mode = 1'b0;
   int          z_hits = 0;
   int          d_run = 0;
   logic        d_last = 1'b0;
   int          d_pos = 0;
   logic [7:0]  d_word = '0;
   logic [7:0]  d_exp;
   int          det_cnt = 0;
   logic        det_last = 1'b0;
   sym_t        e;

   function automatic void chk(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // '0'/'1' data bits, 'a'/'b' stuff bits of value 0/1; ready expected on
   // the last symbol only; cont=1 means no line gap allowed before it.
   function automatic void push_str(input string p, input bit cont);
      sym_t s;
      for (int i = 0; i < p.len(); i++) begin
         s.b   = (p[i] == "1") || (p[i] == "b");
         s.s   = (p[i] == "a") || (p[i] == "b");
         s.rdy = (i == p.len() - 1);
         s.c   = (i != 0) || cont;
         sym_q.push_back(s);
      end
   endfunction

   // Monitor: symbol scoreboard for directed vectors, de-stuffer for random.
   always @(negedge clock) begin
      if (resetn) begin
         if (sym_mode) begin
            if (bus.w_valid) begin
               if (sym_q.size() == 0) begin
                  chk("unexpected_valid", 32'(bus.w_valid), 32'd0);
               end else begin
                  e = sym_q.pop_front();
                  chk("w", 32'(bus.w), 32'(e.b));
                  chk("stuffed", 32'(bus.stuffed), 32'(e.s));
                  chk("ready", 32'(bus.ready), 32'(e.rdy));
                  chk("busy", 32'(bus.busy), 32'd1);
               end
            end else if (sym_q.size() != 0 && sym_q[0].c) begin
               chk("line_gap", 32'(bus.w_valid), 32'd1);
            end
         end
         if (rnd_mode) begin
            if (bus.w_valid) begin
               if (d_run == MAX_RUN) begin
                  chk("stuff_bit", {30'd0, bus.stuffed, bus.w}, {30'd0, 1'b1, ~d_last});
                  d_run  = 1;
                  d_last = bus.w;
               end else begin
                  chk("data_not_stuffed", 32'(bus.stuffed), 32'd0);
                  d_run  = (d_run > 0 && bus.w == d_last) ? d_run + 1 : 1;
                  d_last = bus.w;
                  d_word[d_pos] = bus.w;
                  d_pos++;
                  if (d_pos == DATA_W) begin
                     d_pos = 0;
                     if (word_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word_extra got %0h required none", d_word);
                     end else begin
                        d_exp = word_q.pop_front();
                        chk("word", 32'(d_word), 32'(d_exp));
                     end
                  end
               end
               det_cnt  = (det_cnt > 0 && bus.w == det_last) ? det_cnt + 1 : 1;
               det_last = bus.w;
               if (det_cnt >= 4) z_hits++;
            end else begin
               d_run   = 0;
               det_cnt = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      bus.load    = 1'b1;
      bus.data_in = 8'($urandom);
      @(negedge clock);
      while (!bus.ready) begin
         bus.data_in = 8'($urandom);
         n++;
         if (n > 100) begin
            errors++;
            $display("FAIL send_timeout got ready=0 required ready=1 within 100 cycles");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "ready never asserted");
         end
         @(negedge clock);
      end
      bus.data_in = d;
      if (rnd_mode) word_q.push_back(d);
      @(posedge clock);
      #1;
      chk("latency_valid", 32'(bus.w_valid), 32'd1);
   endtask

   task automatic go_idle();
      bus.load    = 1'b0;
      bus.data_in = 8'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sym_q.size() != 0 || word_q.size() != 0) && n < 500) begin
         @(posedge clock);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d symbols %0d words left required 0",
                  sym_q.size(), word_q.size());
         sym_q.delete();
         word_q.delete();
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clock);
      chk({tag, "_w_valid"}, 32'(bus.w_valid), 32'd0);
      chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] d;
      int         gap;
      bus.load    = 1'b0;
      bus.data_in = '0;
      #2 resetn = 1'b0;
      #10;
      chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
      chk("rst_w", 32'(bus.w), 32'd0);
      chk("rst_stuffed", 32'(bus.stuffed), 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      push_str("10100101", 1'b0);
      send(8'hA5);
      go_idle();
      drain();
      check_idle("a5");

      push_str("000b000b00", 1'b0);
      send(8'h00);
      go_idle();
      drain();
      check_idle("x00");

      push_str("000b11a100", 1'b0);
      send(8'h38);
      go_idle();
      drain();
      check_idle("x38");

      push_str("111a111a11", 1'b0);
      push_str("1a111a111a1", 1'b1);
      send(8'hFF);
      send(8'hFF);
      go_idle();
      drain();
      check_idle("ffff");

      // Asynchronous reset in the middle of the third bit of 8'h00.
      push_str("000b000b00", 1'b0);
      send(8'h00);
      go_idle();
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      #2;
      chk("pre_rst_popped", 32'(sym_q.size()), 32'd7);
      resetn = 1'b0;
      #1;
      chk("arst_w_valid", 32'(bus.w_valid), 32'd0);
      chk("arst_w", 32'(bus.w), 32'd0);
      chk("arst_stuffed", 32'(bus.stuffed), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      sym_q.delete();
      @(negedge clock);
      resetn = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.ready), 32'd1);
      @(posedge clock);
      #1;
      push_str("10100101", 1'b0);
      send(8'hA5);
      go_idle();
      drain();
      check_idle("a5_again");

      sym_mode = 1'b0;
      rnd_mode = 1'b1;
      d_pos    = 0;
      for (int i = 0; i < 1000; i++) begin
         d   = 8'($urandom);
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            go_idle();
            repeat (gap) @(posedge clock);
            #1;
         end
         send(d);
      end
      go_idle();
      drain();
      check_idle("rnd_end");
      chk("detector_z", 32'(z_hits), 32'd0);
      chk("partial_word", 32'(d_pos), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
